// File: rtl/matmul_engine.sv
// matmul_engine: signed N x N matrix multiply, C = A x B or A x B^T, column-major RAMs.
// Optional output saturation is enabled by defining MATMUL_SAT_EN (default build wraps).
module matmul_engine #(
    parameter int N     = 8,
    parameter int DW    = 8,
    parameter int LANES = 2,
    parameter int CW    = 2*DW+$clog2(N),
    parameter int CCW   = 16,
    localparam int AW   = 2*$clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  trans_b,
    output logic                  busy,
    output logic                  done,
    output logic [CCW-1:0]        cycle_count,
    output logic [LANES*AW-1:0]   a_addr,
    input  logic [LANES*DW-1:0]   a_rdata,
    output logic [AW-1:0]         b_addr,
    input  logic [DW-1:0]         b_rdata,
    output logic                  c_we,
    output logic [AW-1:0]         c_addr,
    output logic [CW-1:0]         c_wdata
);

    localparam int LN  = $clog2(N);
    localparam int KW  = LN + 1;
    localparam int NG  = N / LANES;
    localparam int WLW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int RGW = (NG > 1) ? $clog2(NG) : 1;
    localparam int ACW = 2*DW + LN;
    localparam int MW  = (CW > ACW) ? CW : ACW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

`ifdef MATMUL_SAT_EN
    localparam logic signed [MW-1:0] CMAX =
        {{(MW-CW+1){1'b0}}, {(CW-1){1'b1}}};
    localparam logic signed [MW-1:0] CMIN = ~CMAX;
`endif

    logic [1:0]             state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [WLW-1:0]         lane_q, lane_d;
    logic [RGW-1:0]         rg_q, rg_d;
    logic [LN-1:0]          col_q, col_d;
    logic                   trans_q, trans_d;
    logic [CCW-1:0]         cnt_q, cnt_d;
    logic signed [ACW-1:0]  acc_q [LANES];
    logic signed [ACW-1:0]  acc_d [LANES];
    logic [LANES*AW-1:0]    a_addr_q, a_addr_d;
    logic [AW-1:0]          b_addr_q, b_addr_d;
    logic                   c_we_q, c_we_d;
    logic [AW-1:0]          c_addr_q, c_addr_d;
    logic [CW-1:0]          c_wdata_q, c_wdata_d;
    logic [LN-1:0]          r0_d;
    logic [LN-1:0]          kk_d;

    // Narrow a full-precision sum to CW bits: clamp or keep the low bits.
    function automatic logic [CW-1:0] reduce(input logic signed [ACW-1:0] v);
        logic signed [MW-1:0] ve;
        ve = MW'(v);
`ifdef MATMUL_SAT_EN
        if (ve > CMAX) begin
            ve = CMAX;
        end else if (ve < CMIN) begin
            ve = CMIN;
        end
`endif
        return ve[CW-1:0];
    endfunction

    // Sequencer: k inner, row groups middle, columns outer.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        lane_d  = lane_q;
        rg_d    = rg_q;
        col_d   = col_q;
        trans_d = trans_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_MAC;
                    trans_d = trans_b;
                    cnt_d   = '0;
                    col_d   = '0;
                    rg_d    = '0;
                    k_d     = '0;
                    lane_d  = '0;
                end
            end
            S_MAC: begin
                cnt_d = cnt_q + 1'b1;
                if (k_q == KW'(N)) begin
                    state_d = S_WRITE;
                    k_d     = '0;
                    lane_d  = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_WRITE: begin
                cnt_d = cnt_q + 1'b1;
                if (lane_q == WLW'(LANES-1)) begin
                    lane_d = '0;
                    if (rg_q == RGW'(NG-1)) begin
                        rg_d = '0;
                        if (col_q == LN'(N-1)) begin
                            state_d = S_DONE;
                        end else begin
                            col_d   = col_q + 1'b1;
                            state_d = S_MAC;
                        end
                    end else begin
                        rg_d    = rg_q + 1'b1;
                        state_d = S_MAC;
                    end
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Accumulate returned products; the first product of a group loads.
    always_comb begin
        acc_d = acc_q;
        if (state_q == S_MAC && k_q != '0) begin
            for (int l = 0; l < LANES; l++) begin
                acc_d[l] = (k_q == KW'(1) ? '0 : acc_q[l])
                         + ACW'($signed(a_rdata[l*DW +: DW])
                                * $signed(b_rdata));
            end
        end
    end

    // Next-cycle addresses and write data, registered for the outputs.
    always_comb begin
        r0_d = LN'(rg_d * LANES);
        kk_d = k_d[LN-1:0];
        for (int l = 0; l < LANES; l++) begin
            a_addr_d[l*AW +: AW] = {kk_d, r0_d + LN'(l)};
        end
        b_addr_d  = trans_d ? {kk_d, col_d} : {col_d, kk_d};
        c_we_d    = (state_d == S_WRITE);
        c_addr_d  = c_we_d ? {col_d, r0_d + LN'(lane_d)} : c_addr_q;
        c_wdata_d = c_we_d ? reduce(acc_d[lane_d]) : c_wdata_q;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            lane_q    <= '0;
            rg_q      <= '0;
            col_q     <= '0;
            trans_q   <= 1'b0;
            cnt_q     <= '0;
            a_addr_q  <= '0;
            b_addr_q  <= '0;
            c_we_q    <= 1'b0;
            c_addr_q  <= '0;
            c_wdata_q <= '0;
            for (int l = 0; l < LANES; l++) begin
                acc_q[l] <= '0;
            end
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            lane_q    <= lane_d;
            rg_q      <= rg_d;
            col_q     <= col_d;
            trans_q   <= trans_d;
            cnt_q     <= cnt_d;
            a_addr_q  <= a_addr_d;
            b_addr_q  <= b_addr_d;
            c_we_q    <= c_we_d;
            c_addr_q  <= c_addr_d;
            c_wdata_q <= c_wdata_d;
            for (int l = 0; l < LANES; l++) begin
                acc_q[l] <= acc_d[l];
            end
        end
    end

    assign busy        = (state_q == S_MAC) || (state_q == S_WRITE);
    assign done        = (state_q == S_DONE);
    assign cycle_count = cnt_q;
    assign a_addr      = a_addr_q;
    assign b_addr      = b_addr_q;
    assign c_we        = c_we_q;
    assign c_addr      = c_addr_q;
    assign c_wdata     = c_wdata_q;

endmodule

// File: tb/tb_matmul_engine.sv
// tb_matmul_engine: scoreboard bench for matmul_engine.
// Three instances: N=8/LANES=2 at full and 16-bit width, and N=4/LANES=4.
module tb_matmul_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, trans_b, start4, trans4;

    logic        busy_m, done_m, c_we_m;
    logic [15:0] cc_m;
    logic [11:0] a_addr_m;
    logic [15:0] a_rdata_m;
    logic [5:0]  b_addr_m, c_addr_m;
    logic [7:0]  b_rdata_m;
    logic [18:0] c_wdata_m;

    logic        busy_w, done_w, c_we_w;
    logic [15:0] cc_w;
    logic [11:0] a_addr_w;
    logic [5:0]  b_addr_w, c_addr_w;
    logic [15:0] c_wdata_w;

    logic        busy_4, done_4, c_we_4;
    logic [15:0] cc_4;
    logic [15:0] a_addr_4;
    logic [31:0] a_rdata_4;
    logic [3:0]  b_addr_4, c_addr_4;
    logic [7:0]  b_rdata_4;
    logic [17:0] c_wdata_4;

    matmul_engine #(.N(8), .DW(8), .LANES(2)) u_main (
        .clk(clk), .reset(rst_n), .start(start), .trans_b(trans_b),
        .busy(busy_m), .done(done_m), .cycle_count(cc_m),
        .a_addr(a_addr_m), .a_rdata(a_rdata_m),
        .b_addr(b_addr_m), .b_rdata(b_rdata_m),
        .c_we(c_we_m), .c_addr(c_addr_m), .c_wdata(c_wdata_m)
    );

    matmul_engine #(.N(8), .DW(8), .LANES(2), .CW(16)) u_w16 (
        .clk(clk), .reset(rst_n), .start(start), .trans_b(trans_b),
        .busy(busy_w), .done(done_w), .cycle_count(cc_w),
        .a_addr(a_addr_w), .a_rdata(a_rdata_m),
        .b_addr(b_addr_w), .b_rdata(b_rdata_m),
        .c_we(c_we_w), .c_addr(c_addr_w), .c_wdata(c_wdata_w)
    );

    matmul_engine #(.N(4), .DW(8), .LANES(4)) u_n4 (
        .clk(clk), .reset(rst_n), .start(start4), .trans_b(trans4),
        .busy(busy_4), .done(done_4), .cycle_count(cc_4),
        .a_addr(a_addr_4), .a_rdata(a_rdata_4),
        .b_addr(b_addr_4), .b_rdata(b_rdata_4),
        .c_we(c_we_4), .c_addr(c_addr_4), .c_wdata(c_wdata_4)
    );

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t q19[$];
    exp_t q16[$];
    exp_t q4[$];
    exp_t e19, e16, e4;

    int checks = 0;
    int errors = 0;
    int lock_err = 0;

    logic signed [7:0] am [64];
    logic signed [7:0] bm [64];
    logic signed [7:0] a4 [16];
    logic signed [7:0] b4 [16];

`ifdef MATMUL_SAT_EN
    localparam int NEG16 = 32767;
    localparam int POS16 = 32767;
`else
    localparam int NEG16 = 0;
    localparam int POS16 = -2040;
`endif

    // Synchronous-read RAM models, one cycle of latency.
    always @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            a_rdata_m[l*8 +: 8] <= am[a_addr_m[l*6 +: 6]];
        end
        b_rdata_m <= bm[b_addr_m];
        for (int l = 0; l < 4; l++) begin
            a_rdata_4[l*8 +: 8] <= a4[a_addr_4[l*4 +: 4]];
        end
        b_rdata_4 <= b4[b_addr_4];
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", nm, act, req);
        end
    endtask

    function automatic int red16(input int v);
        int w;
        w = v & 32'hFFFF;
        if (w > 32767) w = w - 65536;
`ifdef MATMUL_SAT_EN
        w = (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
`endif
        return w;
    endfunction

    // Monitor for the full-width N=8 instance, plus lockstep of the 16-bit twin.
    always @(negedge clk) begin
        if (a_addr_w != a_addr_m || b_addr_w != b_addr_m ||
            busy_w != busy_m || done_w != done_m || cc_w != cc_m ||
            c_we_w != c_we_m || c_addr_w != c_addr_m) begin
            lock_err++;
        end
        if (c_we_m) begin
            if (q19.size() == 0) begin
                chk("c19_extra_write", int'(c_addr_m), -1);
            end else begin
                e19 = q19.pop_front();
                chk("c19_addr", int'(c_addr_m), e19.addr);
                chk("c19_data", int'($signed(c_wdata_m)), e19.data);
            end
        end
    end

    // Monitor for the 16-bit output instance.
    always @(negedge clk) begin
        if (c_we_w) begin
            if (q16.size() == 0) begin
                chk("c16_extra_write", int'(c_addr_w), -1);
            end else begin
                e16 = q16.pop_front();
                chk("c16_addr", int'(c_addr_w), e16.addr);
                chk("c16_data", int'($signed(c_wdata_w)), e16.data);
            end
        end
    end

    // Monitor for the N=4 instance.
    always @(negedge clk) begin
        if (c_we_4) begin
            if (q4.size() == 0) begin
                chk("c4_extra_write", int'(c_addr_4), -1);
            end else begin
                e4 = q4.pop_front();
                chk("c4_addr", int'(c_addr_4), e4.addr);
                chk("c4_data", int'($signed(c_wdata_4)), e4.data);
            end
        end
    end

    task automatic push_const(input int v19, input int v16);
        for (int i = 0; i < 64; i++) begin
            q19.push_back('{i, v19});
            q16.push_back('{i, v16});
        end
    endtask

    task automatic push_identity();
        for (int i = 0; i < 64; i++) begin
            q19.push_back('{i, int'(bm[i])});
            q16.push_back('{i, int'(bm[i])});
        end
    endtask

    task automatic push_model(input bit tr);
        int s;
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) begin
                s = 0;
                for (int k = 0; k < 8; k++) begin
                    s += int'(am[r+8*k]) *
                         int'(tr ? bm[c+8*k] : bm[k+8*c]);
                end
                q19.push_back('{r+8*c, s});
                q16.push_back('{r+8*c, red16(s)});
            end
        end
    endtask

    task automatic fill_identity();
        for (int i = 0; i < 64; i++) begin
            am[i] = ((i % 8) == (i / 8)) ? 8'sd1 : 8'sd0;
            bm[i] = 8'((i*37 + 11) % 256 - 128);
        end
    endtask

    task automatic run_main(input bit tr, input bit tgl, input int abort_at);
        int bc, lat, guard, extra;
        trans_b = tr;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        bc = 0;
        lat = 0;
        guard = 0;
        while (!done_m && guard < 2000) begin
            if (busy_m) bc++;
            if (c_we_m && lat == 0) lat = bc;
            if (tgl && bc == 50) trans_b = ~trans_b;
            if (abort_at != 0 && bc == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_busy", int'(busy_m), 0);
                chk("rst_c_we", int'(c_we_m), 0);
                chk("rst_cycle_count", int'(cc_m), 0);
                q19.delete();
                q16.delete();
                @(negedge clk) rst_n = 1'b1;
                return;
            end
            start = (bc == 100);
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        chk("done_seen", int'(done_m), 1);
        chk("busy_in_done", int'(busy_m), 0);
        chk("busy_cycles", bc, 352);
        chk("cycle_count", int'(cc_m), 352);
        chk("first_we_latency", lat, 10);
        start = 1'b1;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            start = 1'b0;
            if (busy_m || done_m) extra++;
        end
        chk("no_second_run", extra, 0);
        chk("count_hold", int'(cc_m), 352);
        chk("q19_drained", q19.size(), 0);
        chk("q16_drained", q16.size(), 0);
        trans_b = 1'b0;
    endtask

    task automatic run4();
        int bc, guard, extra, s;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                s = 0;
                for (int k = 0; k < 4; k++) begin
                    s += int'(a4[r+4*k]) * int'(b4[k+4*c]);
                end
                q4.push_back('{r+4*c, s});
            end
        end
        @(negedge clk) start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        bc = 0;
        guard = 0;
        while (!done_4 && guard < 500) begin
            if (busy_4) bc++;
            start4 = (bc == 10);
            @(negedge clk);
            guard++;
        end
        start4 = 1'b0;
        chk("n4_done_seen", int'(done_4), 1);
        chk("n4_busy_cycles", bc, 36);
        chk("n4_cycle_count", int'(cc_4), 36);
        start4 = 1'b1;
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            start4 = 1'b0;
            if (busy_4 || done_4) extra++;
        end
        chk("n4_no_second_run", extra, 0);
        chk("q4_drained", q4.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        trans_b = 1'b0;
        start4 = 1'b0;
        trans4 = 1'b0;
        fill_identity();
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy_m), 0);
        chk("reset_done", int'(done_m), 0);
        chk("reset_c_we", int'(c_we_m), 0);
        chk("reset_count", int'(cc_m), 0);
        chk("reset_a_addr", int'(a_addr_m), 0);
        chk("reset_b_addr", int'(b_addr_m), 0);
        chk("reset_c_addr", int'(c_addr_m), 0);
        chk("reset_c_wdata", int'(c_wdata_m), 0);
        chk("reset_n4_c_we", int'(c_we_4), 0);
        @(negedge clk) rst_n = 1'b1;

        push_identity();
        run_main(1'b0, 1'b0, 0);

        for (int i = 0; i < 64; i++) begin
            am[i] = -8'sd128;
            bm[i] = -8'sd128;
        end
        push_const(131072, NEG16);
        run_main(1'b0, 1'b0, 0);

        for (int i = 0; i < 64; i++) begin
            am[i] = 8'sd127;
            bm[i] = 8'sd127;
        end
        push_const(129032, POS16);
        run_main(1'b0, 1'b0, 0);

        for (int i = 0; i < 64; i++) begin
            am[i] = 8'((i*13 + 5) % 31 - 15);
            bm[i] = 8'((i % 8) - (i / 8));
        end
        push_model(1'b1);
        run_main(1'b1, 1'b1, 0);

        fill_identity();
        push_identity();
        run_main(1'b0, 1'b0, 100);
        push_identity();
        run_main(1'b0, 1'b0, 0);

        for (int i = 0; i < 16; i++) begin
            a4[i] = 8'((i*29 + 3) % 255 - 127);
            b4[i] = 8'(100 - (i*41) % 200);
        end
        run4();

        chk("w16_lockstep", lock_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
